// File: rtl/rand_pkg.sv
// ----------------------------------------------------------------------------
// rand_pkg
// Shared types and default constants for the random food-coordinate
// generator: the request FSM state encoding and the default 9-bit Galois
// tap mask / reset seed inherited from the original food-position LFSR.
// Optional build macro used by the importing modules: RAND_LOCKUP_GUARD_EN.
// ----------------------------------------------------------------------------
package rand_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      RESP = 2'd2
   } rand_state_e;

   localparam logic [8:0] DEFAULT_TAPS = 9'h070;
   localparam logic [8:0] DEFAULT_SEED = 9'd132;

endpackage

// File: rtl/rand_coord_gen_lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// Galois LFSR state register with synchronous load and optional lock-up
// guard.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (state <= RESET_SEED)
//   step_i   in   advance the LFSR one step this cycle
//   load_i   in   load seed_i (priority over step_i)
//   seed_i   in   seed value
//   state_o  out  current LFSR state
// Build macro RAND_LOCKUP_GUARD_EN: when defined, a zero seed loads
// RESET_SEED instead and a zero state is replaced by RESET_SEED on the next
// edge, so the register can never stick at zero.
// ----------------------------------------------------------------------------
module lfsr_core
   import rand_pkg::*;
#(
   parameter int unsigned          WIDTH      = 9,
   parameter logic [WIDTH-1:0]     TAPS       = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0]     RESET_SEED = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   output logic [WIDTH-1:0] state_o
);

   // Bit 0 of the tap mask has no effect: next[0] is always the feedback bit.
   localparam logic [WIDTH-1:0] TAP_MASK = {TAPS[WIDTH-1:1], 1'b0};

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] step_val;
   logic             feedback;

   assign feedback = state_q[WIDTH-1];
   assign step_val = {state_q[WIDTH-2:0], feedback} ^ (TAP_MASK & {WIDTH{feedback}});

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (step_i) begin
         state_d = step_val;
      end
`ifdef RAND_LOCKUP_GUARD_EN
      if (load_i && (seed_i == '0)) begin
         state_d = RESET_SEED;
      end else if (!load_i && (state_q == '0)) begin
         state_d = RESET_SEED;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/rand_coord_gen.sv
// ----------------------------------------------------------------------------
// rand_coord_gen
// Food-placement coordinate generator. Wraps a parametrised Galois LFSR and
// answers coordinate requests by rejection sampling: each DRAW cycle the low
// LFSR bits form a candidate (x, y) that is queried against the external
// body-map occupancy; the first on-grid free candidate is returned, or a
// failure after MAX_TRIES rejected candidates.
//   clk, rst_n            clock / asynchronous active-low reset
//   en, load, seed        free-running LFSR control (load > draw > en)
//   rand_num              current LFSR state
//   req                   coordinate request, accepted only in IDLE
//   cand_valid/x/y        candidate being queried (DRAW state)
//   occ_hit               combinational occupancy answer for the candidate
//   rsp_valid/ready       response handshake, held until accepted
//   rsp_x/y/fail          returned cell, or fail with (0,0)
// Build macro RAND_LOCKUP_GUARD_EN: forwarded to lfsr_core (zero lock-up
// guard). Default build leaves the guard out.
// ----------------------------------------------------------------------------
module rand_coord_gen
   import rand_pkg::*;
#(
   parameter int unsigned      WIDTH      = 9,
   parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(DEFAULT_SEED),
   parameter int unsigned      GRID_W     = 20,
   parameter int unsigned      GRID_H     = 15,
   parameter int unsigned      MAX_TRIES  = 8,
   localparam int unsigned     XW         = $clog2(GRID_W),
   localparam int unsigned     YW         = $clog2(GRID_H)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] rand_num,
   input  logic             req,
   output logic             cand_valid,
   output logic [XW-1:0]    cand_x,
   output logic [YW-1:0]    cand_y,
   input  logic             occ_hit,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XW-1:0]    rsp_x,
   output logic [YW-1:0]    rsp_y,
   output logic             rsp_fail
);

   localparam int unsigned     CW    = $clog2(MAX_TRIES + 1);
   localparam logic [CW-1:0]   MAX_T = CW'(MAX_TRIES);

   rand_state_e      state_q, state_d;
   logic [CW-1:0]    tries_q, tries_d;
   logic [CW-1:0]    tries_inc;
   logic [XW-1:0]    rsp_x_q, rsp_x_d;
   logic [YW-1:0]    rsp_y_q, rsp_y_d;
   logic             rsp_fail_q, rsp_fail_d;
   logic             lfsr_step;
   logic             in_grid;
   logic             cand_ok;

   // The LFSR advances every DRAW cycle so that each retry sees a fresh
   // candidate, independent of en.
   assign lfsr_step = (state_q == DRAW) || en;

   lfsr_core #(
      .WIDTH      (WIDTH),
      .TAPS       (TAPS),
      .RESET_SEED (RESET_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (lfsr_step),
      .load_i  (load),
      .seed_i  (seed),
      .state_o (rand_num)
   );

   assign cand_x     = rand_num[XW-1:0];
   assign cand_y     = rand_num[XW+YW-1:XW];
   assign cand_valid = (state_q == DRAW);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_x      = rsp_x_q;
   assign rsp_y      = rsp_y_q;
   assign rsp_fail   = rsp_fail_q;

   // Extra MSB on the compare so a power-of-two grid dimension still fits.
   assign in_grid = ({1'b0, cand_x} < (XW+1)'(GRID_W)) &&
                    ({1'b0, cand_y} < (YW+1)'(GRID_H));
   assign cand_ok = in_grid && !occ_hit;

   // Saturating increment of the try counter.
   assign tries_inc = (tries_q == MAX_T) ? tries_q : tries_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      rsp_x_d    = rsp_x_q;
      rsp_y_d    = rsp_y_q;
      rsp_fail_d = rsp_fail_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               tries_d = '0;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (cand_ok) begin
               rsp_x_d    = cand_x;
               rsp_y_d    = cand_y;
               rsp_fail_d = 1'b0;
               state_d    = RESP;
            end else begin
               tries_d = tries_inc;
               if (tries_inc >= MAX_T) begin
                  rsp_x_d    = '0;
                  rsp_y_d    = '0;
                  rsp_fail_d = 1'b1;
                  state_d    = RESP;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tries_q    <= '0;
         rsp_x_q    <= '0;
         rsp_y_q    <= '0;
         rsp_fail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tries_q    <= tries_d;
         rsp_x_q    <= rsp_x_d;
         rsp_y_q    <= rsp_y_d;
         rsp_fail_q <= rsp_fail_d;
      end
   end

endmodule

// File: doc/rand_coord_gen.md
# rand_coord_gen

Parametrised successor to the 9-bit food-position LFSR. It generalises the shift register in width, tap polynomial and reset seed, and adds a request/response port. Over that port it returns an on-grid (x, y) coordinate that is not on the snake's body, using rejection sampling against an external occupancy lookup. The block sits between the game FSM, which requests food placement, and the body-map RAM, which answers occupancy queries.

## Interface
Parameters:
- WIDTH, 9, LFSR state width (≥ XW+YW).
- TAPS, 9'h070, Galois feedback mask; bit 0 is ignored.
- RESET_SEED, 9'd132, state after reset; must be non-zero.
- GRID_W, 20, grid columns; XW = $clog2(GRID_W).
- GRID_H, 15, grid rows; YW = $clog2(GRID_H).
- MAX_TRIES, 8, candidates examined per request before failing (≥ 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance the LFSR this cycle.
- load  in  1  load `seed` into the state; has priority over `en`.
- seed  in  WIDTH  seed value.
- rand_num  out  WIDTH  current LFSR state.
- req  in  1  coordinate request; accepted only in IDLE.
- cand_valid  out  1  high in DRAW; `cand_x`/`cand_y` are being queried.
- cand_x  out  XW  candidate column = rand_num[XW-1:0].
- cand_y  out  YW  candidate row = rand_num[XW+YW-1:XW].
- occ_hit  in  1  combinational occupancy of (cand_x, cand_y), same cycle.
- rsp_valid  out  1  response valid; held until `rsp_ready`.
- rsp_ready  in  1  consumer accepts the response.
- rsp_x  out  XW  returned column.
- rsp_y  out  YW  returned row.
- rsp_fail  out  1  no free cell found within MAX_TRIES.

## Operation
- LFSR step, with m = state[WIDTH-1]:
  - next[0] = m
  - next[i] = state[i-1] ^ (TAPS[i] & m), for 1 ≤ i < WIDTH
- LFSR priority per cycle: load > DRAW (always steps) > en > hold.
- The LFSR steps every DRAW cycle regardless of `en`, so each retry sees a fresh candidate.
- FSM states:
  - IDLE: on `req`, clear the try counter and go to DRAW.
  - DRAW: the candidate is accepted iff cand_x < GRID_W, cand_y < GRID_H and !occ_hit. On accept, register cand_x/cand_y into rsp_x/rsp_y with rsp_fail = 0 and go to RESP. On reject, increment the try counter; when it reaches MAX_TRIES, set rsp_x = rsp_y = 0 and rsp_fail = 1, then go to RESP.
  - RESP: `rsp_valid` = 1 and the rsp_* outputs are stable. On `rsp_ready`, go to IDLE.
- `occ_hit` is ignored outside DRAW. `req` is ignored outside IDLE; it is not queued.
- `load` during DRAW replaces the state; the draw continues from the loaded value on the next cycle.
- The try counter is $clog2(MAX_TRIES+1) bits wide and saturates.

## Timing
- Reset values:
  - rand_num = RESET_SEED
  - state = IDLE
  - rsp_valid = 0, rsp_fail = 0, rsp_x = 0, rsp_y = 0, cand_valid = 0
- `load` at edge t puts `seed` on rand_num after edge t.
- `req` sampled at edge t gives DRAW in cycle t+1.
- A first-try accept gives rsp_valid in cycle t+2, i.e. 2-cycle latency. Each reject adds one cycle. Worst case is MAX_TRIES+1 cycles.
- `rsp_valid` deasserts the cycle after the rsp_valid && rsp_ready handshake edge. A new `req` is accepted no earlier than the following cycle.
- Reset asserted mid-draw or mid-response aborts immediately to the reset values; no response is issued.

## Configuration
- RAND_LOCKUP_GUARD_EN:
  - Defined: a load of all-zero `seed` loads RESET_SEED instead, and any zero state is replaced by RESET_SEED on the next edge. The generator therefore never locks up.
  - Undefined: zero loads as zero, and the LFSR stays at 0 permanently. A request then returns a cell only if (0,0) is free; otherwise it returns rsp_fail after MAX_TRIES.

## Structure
- Package rand_pkg holds:
  - the FSM state enum (IDLE, DRAW, RESP);
  - default constants: the 9-bit tap mask 9'h070 and the seed 9'd132.
- Sub-module lfsr_core contains the state register, the step logic and the load/lockup-guard logic, parametrised by WIDTH/TAPS/RESET_SEED. rand_coord_gen instantiates it and adds the FSM, the try counter and the response registers.

## Test plan
- Reset, en=1 for 2 cycles: rand_num goes 132 → 264 → 97.
- load=1 and en=1 together with seed=9'h1AB: rand_num = 9'h1AB next cycle, not stepped.
- With occ_hit=0, load a seed whose cand_x is 4 (<20) and cand_y is 3 (<15), then pulse req: rsp_valid 2 cycles later with rsp_x=4, rsp_y=3, rsp_fail=0.
- Hold occ_hit=1 with MAX_TRIES=8, then pulse req: exactly 8 cand_valid cycles, then rsp_valid with rsp_fail=1, rsp_x=0, rsp_y=0.
- Hold rsp_ready=0 for 5 cycles while pulsing req during RESP: the response stays stable and the extra req is dropped. rsp_ready=1 returns the FSM to IDLE.
- Load seed=0: with RAND_LOCKUP_GUARD_EN, rand_num = 132. Without it, rand_num stays 0 for 10 enabled cycles.
- Assert rst_n=0 mid-DRAW: all outputs take their reset values asynchronously.
